// File: rtl/coef_group_sched_if.sv
// Coefficient-in / group-out handshake bundle for the coefficient group sequencer.
// slave is the sequencer side; master is the upstream/downstream side.
interface coef_group_sched_if #(
    parameter int IWID  = 12,
    parameter int GROUP = 4
);
    logic                  in_valid;
    logic [IWID-1:0]       in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [IWID*GROUP-1:0] out_data;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/coef_group_sched.sv
// Serial-in / parallel-out coefficient sequencer: packs GROUP coefficients per output word
// and frames NCOEF coefficients per start command, flagging the last group and pulsing done.
//
// state  | meaning
// IDLE   | waiting for start; no traffic accepted or offered
// FILL   | accepting coefficients into the window
// HOLD   | presenting a completed group until the downstream handshake
// DONE   | one-cycle done pulse after the final group, then back to IDLE
module coef_group_sched #(
    parameter int IWID  = 12,
    parameter int GROUP = 4,
    parameter int NCOEF = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    coef_group_sched_if.slave bus,
    output logic              busy,
    output logic              done
);
    localparam int NGRP = NCOEF / GROUP;
    localparam int GCW  = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int LCW  = $clog2(GROUP);
    localparam int W    = IWID * GROUP;

    localparam logic [LCW-1:0] LANE_MAX = LCW'(GROUP - 1);
    localparam logic [GCW-1:0] GRP_MAX  = GCW'(NGRP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [LCW-1:0] lane_cnt_q, lane_cnt_d;
    logic [GCW-1:0] grp_cnt_q, grp_cnt_d;
    logic [W-1:0]   window_q, window_d;

    logic accept;
    logic out_hs;
    logic last_grp;

    assign accept   = (state_q == S_FILL) && bus.in_valid;
    assign out_hs   = (state_q == S_HOLD) && bus.out_ready;
    assign last_grp = (grp_cnt_q == GRP_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lane_cnt_q <= '0;
            grp_cnt_q  <= '0;
            window_q   <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            window_q   <= window_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        grp_cnt_d  = grp_cnt_q;
        window_d   = window_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FILL;
                    lane_cnt_d = '0;
                    grp_cnt_d  = '0;
                end
            end
            S_FILL: begin
                if (accept) begin
                    // newest coefficient enters the top lane so lane 0 ends up holding the oldest
                    window_d = {bus.in_data, window_q[W-1:IWID]};
                    if (lane_cnt_q == LANE_MAX) begin
                        lane_cnt_d = '0;
                        state_d    = S_HOLD;
                    end else begin
                        lane_cnt_d = lane_cnt_q + LCW'(1);
                    end
                end
            end
            S_HOLD: begin
                if (out_hs) begin
                    if (last_grp) begin
                        state_d = S_DONE;
                    end else begin
                        grp_cnt_d = grp_cnt_q + GCW'(1);
                        state_d   = S_FILL;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == S_FILL);
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_data  = window_q;
    assign bus.out_last  = (state_q == S_HOLD) && last_grp;
    assign busy          = (state_q == S_FILL) || (state_q == S_HOLD);
    assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_coef_group_sched.sv
// Randomized bench for coef_group_sched: a default-sized instance checked against a
// count-based reference (accepted vs. emitted coefficients), plus a small NCOEF=8/GROUP=2 instance.
module tb_coef_group_sched;
    localparam int IWID  = 12;
    localparam int GROUP = 4;
    localparam int NCOEF = 256;
    localparam int NG    = NCOEF / GROUP;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic busy_a, done_a, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    coef_group_sched_if #(.IWID(IWID), .GROUP(GROUP)) a_if ();
    coef_group_sched_if #(.IWID(IWID), .GROUP(2))     b_if ();

    coef_group_sched #(.IWID(IWID), .GROUP(GROUP), .NCOEF(NCOEF)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .start (start_a),
        .bus   (a_if),
        .busy  (busy_a),
        .done  (done_a)
    );

    coef_group_sched #(.IWID(IWID), .GROUP(2), .NCOEF(8)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .start (start_b),
        .bus   (b_if),
        .busy  (busy_b),
        .done  (done_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IWID-1:0] coef(input int base, input int i);
        int v;
        v = (base + i) % 4096;
        return IWID'(v);
    endfunction

    // One polynomial on instance A. The reference tracks how many coefficients were accepted
    // (idx) and how many groups were emitted (g); from those the expected state follows directly.
    task automatic run_poly(input int base, input int vin_pct, input int rdy_pct,
                            input int stall_grp, input int abort_at, input int exp_cycles,
                            input bit poke_start);
        int idx, g, cyc, done_cnt, stall_left, pend;
        bit fin;
        bit hs_in, hs_out;
        idx = 0; g = 0; cyc = 0; done_cnt = 0; stall_left = 10; fin = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 1;
        while (!fin) begin
            if (cyc > 5000) begin
                chk("poly_timeout_done_seen", 64'(done_cnt), 64'd1);
                return;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b1;
                a_if.in_valid  = 1'b0;
                a_if.out_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_busy", 64'(busy_a), 64'd0);
                chk("rst_out_valid", 64'(a_if.out_valid), 64'd0);
                chk("rst_in_ready", 64'(a_if.in_ready), 64'd0);
                chk("rst_done", 64'(done_a), 64'd0);
                chk("rst_out_data", 64'(a_if.out_data), 64'd0);
                return;
            end
            pend = idx - GROUP * g;
            if (g == NG) begin
                chk("done_pulse", 64'(done_a), 64'd1);
                chk("done_once", 64'(done_cnt), 64'd0);
                chk("busy_in_done", 64'(busy_a), 64'd0);
                chk("accepted_total", 64'(idx), 64'(NCOEF));
                if (exp_cycles > 0) chk("start_to_done_cycles", 64'(cyc), 64'(exp_cycles));
                done_cnt++;
                start_a        = poke_start;
                a_if.in_valid  = 1'b1;
                a_if.in_data   = 12'h5A5;
                a_if.out_ready = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
                chk("idle_after_done_busy", 64'(busy_a), 64'd0);
                chk("idle_after_done_in_ready", 64'(a_if.in_ready), 64'd0);
                chk("idle_after_done_done", 64'(done_a), 64'd0);
                a_if.in_valid = 1'b0;
                fin = 1'b1;
            end else begin
                chk("done_early", 64'(done_a), 64'd0);
                chk("busy", 64'(busy_a), 64'd1);
                chk("out_valid", 64'(a_if.out_valid), 64'(pend == GROUP));
                chk("in_ready", 64'(a_if.in_ready), 64'(pend < GROUP));
                if (pend == GROUP) begin
                    for (int k = 0; k < GROUP; k++)
                        chk($sformatf("g%0d_lane%0d", g, k),
                            64'(a_if.out_data[k*IWID +: IWID]), 64'(coef(base, GROUP * g + k)));
                    chk("out_last", 64'(a_if.out_last), 64'(g == NG - 1));
                end else begin
                    chk("out_last_idle", 64'(a_if.out_last), 64'd0);
                end
                // drive this cycle's inputs; they take effect at the coming rising edge
                a_if.in_valid = (idx < NCOEF) && ($urandom_range(99) < 32'(vin_pct));
                a_if.in_data  = coef(base, idx);
                if (pend == GROUP && g == stall_grp && stall_left > 0) begin
                    a_if.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    a_if.out_ready = ($urandom_range(99) < 32'(rdy_pct));
                end
                start_a = poke_start && (cyc % 7 == 3);
                hs_in  = a_if.in_valid && (pend < GROUP);
                hs_out = a_if.out_ready && (pend == GROUP);
                if (hs_in)  idx++;
                if (hs_out) g++;
                @(negedge clk);
                start_a = 1'b0;
                cyc++;
            end
        end
    endtask

    task automatic run_small();
        int bidx, bg, cyc;
        bidx = 0; bg = 0; cyc = 0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        while (!done_b && cyc < 100) begin
            if (b_if.out_valid) begin
                chk($sformatf("small_g%0d_lane0", bg), 64'(b_if.out_data[IWID-1:0]), 64'(10 + 2 * bg));
                chk($sformatf("small_g%0d_lane1", bg), 64'(b_if.out_data[2*IWID-1:IWID]), 64'(11 + 2 * bg));
                chk($sformatf("small_g%0d_last", bg), 64'(b_if.out_last), 64'(bg == 3));
                bg++;
            end
            b_if.in_valid  = (bidx < 8);
            b_if.in_data   = IWID'(10 + bidx);
            b_if.out_ready = 1'b1;
            if (b_if.in_valid && b_if.in_ready) bidx++;
            @(negedge clk);
            cyc++;
        end
        chk("small_done", 64'(done_b), 64'd1);
        chk("small_groups", 64'(bg), 64'd4);
        b_if.in_valid = 1'b0;
        @(negedge clk);
        chk("small_done_cleared", 64'(done_b), 64'd0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 64'(busy_a), 64'd0);
        chk("reset_done", 64'(done_a), 64'd0);
        chk("reset_out_valid", 64'(a_if.out_valid), 64'd0);
        chk("reset_in_ready", 64'(a_if.in_ready), 64'd0);
        chk("reset_out_data", 64'(a_if.out_data), 64'd0);
        chk("reset_out_last", 64'(a_if.out_last), 64'd0);

        // in_valid while IDLE must not be consumed; a stray value would surface in group 0
        a_if.in_valid = 1'b1;
        a_if.in_data  = 12'hABC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_in_ready", 64'(a_if.in_ready), 64'd0);
            chk("idle_busy", 64'(busy_a), 64'd0);
        end
        a_if.in_valid = 1'b0;

        run_poly(0, 100, 100, -1, -1, 321, 1'b0);
        run_poly(0, 100, 100, 5, -1, 331, 1'b0);
        run_poly(0, 50, 100, -1, -1, 0, 1'b0);
        base = int'($urandom_range(4095));
        run_poly(base, 50, 60, 17, -1, 0, 1'b0);
        base = int'($urandom_range(4095));
        run_poly(base, 60, 60, -1, 130, 0, 1'b0);
        run_poly(0, 100, 100, -1, -1, 321, 1'b0);
        base = int'($urandom_range(4095));
        run_poly(base, 80, 80, -1, -1, 0, 1'b1);
        run_small();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
